// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor: one bit per cycle LSB first, valid/ready handshakes on both sides.
// Optional macro SERIAL_SUB_SATURATE_EN clamps a negative result to zero (o_borrow still reports it).
module serial_subtractor #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic                  i_start_valid,
    output logic                  o_start_ready,
    input  logic [DATA_WIDTH-1:0] i_A,
    input  logic [DATA_WIDTH-1:0] i_B,
    output logic [DATA_WIDTH-1:0] o_diff,
    output logic                  o_borrow,
    output logic                  o_valid,
    input  logic                  i_ready
);
    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic                  borrow_q, borrow_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic a_bit, b_bit, d_bit, bout;

    assign a_bit = a_q[0];
    assign b_bit = b_q[0];
    assign d_bit = a_bit ^ b_bit ^ borrow_q;
    assign bout  = (~a_bit & b_bit) | (borrow_q & ~(a_bit ^ b_bit));

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        diff_d        = diff_q;
        borrow_d      = borrow_q;
        cnt_d         = cnt_q;
        o_start_ready = 1'b0;
        o_valid       = 1'b0;
        case (state_q)
            IDLE: begin
                o_start_ready = 1'b1;
                if (i_start_valid) begin
                    a_d      = i_A;
                    b_d      = i_B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                // Entering at the MSB leaves the word aligned after DATA_WIDTH shifts.
                diff_d   = {d_bit, diff_q[DATA_WIDTH-1:1]};
                borrow_d = bout;
                if (cnt_q == LAST) state_d = DONE;
                else               cnt_d   = cnt_q + CW'(1);
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_borrow = borrow_q;
`ifdef SERIAL_SUB_SATURATE_EN
    assign o_diff = (state_q == DONE && borrow_q) ? '0 : diff_q;
`else
    assign o_diff = diff_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (DATA_WIDTH=16): vector table plus handshake/reset corner sequences.
module tb_serial_subtractor;
    localparam int W = 16;

    logic         s_clk = 1'b0;
    logic         s_rst;
    logic         i_start_valid;
    logic         o_start_ready;
    logic [W-1:0] i_A, i_B;
    logic [W-1:0] o_diff;
    logic         o_borrow;
    logic         o_valid;
    logic         i_ready;

    int checks = 0;
    int errors = 0;
    int lat;

    serial_subtractor #(.DATA_WIDTH(W)) dut (
        .s_clk(s_clk), .s_rst(s_rst),
        .i_start_valid(i_start_valid), .o_start_ready(o_start_ready),
        .i_A(i_A), .i_B(i_B),
        .o_diff(o_diff), .o_borrow(o_borrow), .o_valid(o_valid),
        .i_ready(i_ready)
    );

    always #5 s_clk = ~s_clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] expd(input logic [W-1:0] d, input logic bo);
`ifdef SERIAL_SUB_SATURATE_EN
        return bo ? '0 : d;
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    // Handshake in cycle 0, then wait for o_valid; lat = cycle of first o_valid.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
        chk("start_ready_before_op", o_start_ready, 1);
        i_A = a; i_B = b; i_start_valid = 1'b1;
        tick();
        i_start_valid = 1'b0;
        i_A = ~a; i_B = a ^ b;
        lat = 1;
        while (!o_valid && lat < 40) begin
            chk("start_ready_in_calc", o_start_ready, 0);
            if (disturb && lat == 3) begin
                i_start_valid = 1'b1; i_A = 16'd1; i_B = 16'd1;
            end else begin
                i_start_valid = 1'b0;
            end
            tick();
            lat++;
        end
        i_start_valid = 1'b0;
        if (!o_valid) begin
            errors++;
            $display("FAIL timeout o_valid got 0 want 1");
        end
    endtask

    initial begin
        vecs[0]  = '{16'd100,  16'd37,   16'd63,   1'b0};
        vecs[1]  = '{16'd0,    16'd1,    16'hFFFF, 1'b1};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0};
        vecs[3]  = '{16'd500,  16'd200,  16'd300,  1'b0};
        vecs[4]  = '{16'd7,    16'd7,    16'd0,    1'b0};
        vecs[5]  = '{16'd1,    16'd2,    16'hFFFF, 1'b1};
        vecs[6]  = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0};
        vecs[7]  = '{16'h1234, 16'h0235, 16'h0FFF, 1'b0};
        vecs[8]  = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1};
        vecs[9]  = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
        vecs[10] = '{16'h5555, 16'hAAAA, 16'hAAAB, 1'b1};

        s_rst = 1'b1; i_start_valid = 1'b0; i_A = '0; i_B = '0; i_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_diff", o_diff, 0);
        chk("rst_borrow", o_borrow, 0);
        chk("rst_start_ready", o_start_ready, 1);
        s_rst = 1'b0;
        tick();

        // Table: i_ready held high, result accepted the cycle it appears.
        i_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].a, vecs[i].b, 1'b0);
            chk($sformatf("v%0d_latency", i), lat, 17);
            chk($sformatf("v%0d_diff", i), o_diff, expd(vecs[i].d, vecs[i].bo));
            chk($sformatf("v%0d_borrow", i), o_borrow, vecs[i].bo);
            tick();
            chk($sformatf("v%0d_ready_after", i), o_start_ready, 1);
            chk($sformatf("v%0d_valid_after", i), o_valid, 0);
        end

        // Back-pressure: result must hold for 5 stalled cycles.
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] a, b, d;
            logic         bo;
            a  = (k == 0) ? 16'hFFFF : 16'h5555;
            b  = (k == 0) ? 16'hFFFF : 16'hAAAA;
            d  = (k == 0) ? 16'h0000 : 16'hAAAB;
            bo = (k == 1);
            i_ready = 1'b0;
            do_op(a, b, 1'b0);
            chk("hold_latency", lat, 17);
            for (int c = 0; c < 5; c++) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_diff", o_diff, expd(d, bo));
                chk("hold_borrow", o_borrow, bo);
                chk("hold_start_ready", o_start_ready, 0);
                i_start_valid = 1'b1;
                tick();
                i_start_valid = 1'b0;
            end
            chk("hold_still_valid", o_valid, 1);
            i_ready = 1'b1;
            tick();
            chk("hold_release_ready", o_start_ready, 1);
            chk("hold_release_valid", o_valid, 0);
        end

        // Second start pulsed mid-CALC is ignored.
        do_op(16'd500, 16'd200, 1'b1);
        chk("ignore_latency", lat, 17);
        chk("ignore_diff", o_diff, 16'd300);
        chk("ignore_borrow", o_borrow, 0);
        tick();
        chk("ignore_ready_after", o_start_ready, 1);

        // Reset sampled at end of cycle 8 aborts the op.
        i_A = 16'd10; i_B = 16'd3; i_start_valid = 1'b1;
        tick();
        i_start_valid = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        chk("abort_valid", o_valid, 0);
        chk("abort_ready", o_start_ready, 1);
        chk("abort_diff", o_diff, 0);
        begin
            int seen = 0;
            for (int c = 0; c < 20; c++) begin
                if (o_valid) seen++;
                tick();
            end
            chk("abort_no_valid", seen, 0);
        end
        do_op(16'd7, 16'd7, 1'b0);
        chk("after_abort_latency", lat, 17);
        chk("after_abort_diff", o_diff, 0);
        tick();

        // Reset in DONE wins over simultaneous output and start handshakes.
        i_ready = 1'b0;
        do_op(16'd0, 16'd1, 1'b0);
        chk("prio_valid_before", o_valid, 1);
        s_rst = 1'b1; i_ready = 1'b1; i_start_valid = 1'b1; i_A = 16'd9; i_B = 16'd4;
        tick();
        s_rst = 1'b0; i_start_valid = 1'b0;
        chk("prio_valid", o_valid, 0);
        chk("prio_ready", o_start_ready, 1);
        chk("prio_borrow", o_borrow, 0);
        chk("prio_diff", o_diff, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
